// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   lsu_state_t - controller states
//   SZ_B/SZ_H/SZ_W - request size codes (3 is reserved and always misaligned)
//   RESP_OKAY - AXI response code for a successful transfer
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    ERR
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_axi_if.sv
// lsu_axi_if: AXI-lite read and write channels between the load/store unit
// (master) and the interconnect (slave).
//   AR: araddr/arvalid/arready     R: rdata/rresp/rvalid/rready
//   AW: awaddr/awvalid/awready     W: wdata/wstrb/wvalid/wready
//   B : bresp/bvalid/bready
interface lsu_axi_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   size/addr_lo/ld_signed/st_data - registered request fields
//   ld_raw      - AXI read data
//   wstrb/wdata - store strobes and lane-replicated store data
//   ld_data     - load data shifted down and sign/zero-extended
//   chk_size/chk_addr_lo -> misaligned - alignment check of the live request
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        ld_signed,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr_lo,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    shifted = ld_raw >> {addr_lo, 3'b000};
    wstrb   = '0;
    wdata   = '0;
    ld_data = '0;
    case (size)
      SZ_B: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wstrb   = 4'b0011 << addr_lo;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wstrb   = 4'b1111;
        wdata   = st_data;
        ld_data = shifted;
      end
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (chk_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = chk_addr_lo[0];
      SZ_W:    misaligned = |chk_addr_lo;
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_axi.sv
// lsu_axi: single-outstanding CPU load/store unit with an AXI-lite master.
//   clk, rst       - clock, asynchronous active-high reset
//   req_*          - CPU request (valid/ready handshake)
//   resp_*         - one-cycle completion pulse with load data / error flag
//   m_axi          - AXI-lite master channels
module lsu_axi
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  lsu_axi_if.master             m_axi
);

  lsu_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [31:0]           wdata_q;

  logic arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic aw_done, w_done;

  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        req_misaligned;
  logic        aw_fire, w_fire;

  lsu_align u_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .ld_signed   (signed_q),
    .st_data     (wdata_q),
    .ld_raw      (m_axi.rdata),
    .chk_size    (req_size),
    .chk_addr_lo (req_addr[1:0]),
    .wstrb       (st_strb),
    .wdata       (st_wdata),
    .ld_data     (ld_data),
    .misaligned  (req_misaligned)
  );

  assign m_axi.araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign m_axi.awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign m_axi.wdata   = st_wdata;
  assign m_axi.wstrb   = st_strb;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  assign aw_fire = awvalid_q & m_axi.awready;
  assign w_fire  = wvalid_q & m_axi.wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      size_q     <= SZ_B;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          // req_ready is registered, so it comes up one cycle after reset release.
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            signed_q  <= req_signed;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_misaligned) begin
              state <= ERR;
            end else if (req_wen) begin
              state     <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            rready_q   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= (m_axi.rresp != RESP_OKAY);
            resp_rdata <= (m_axi.rresp != RESP_OKAY) ? '0 : ld_data;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          // Fold this cycle's handshakes in so simultaneous AW/W completes at once.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_q   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= (m_axi.bresp != RESP_OKAY);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_axi.md
LSU_AXI -- requirements
Module: lsu_axi

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width of the CPU and AXI-lite address buses.
REQ-002 clk  input  1  single clock; all logic is on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  CPU memory request valid.
REQ-005 req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned).
REQ-008 req_signed  input  1  loads only: sign-extend (1) or zero-extend (0).
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse; the CPU has no backpressure.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  qualifies resp_valid: misaligned access or nonzero rresp/bresp.
REQ-014 m_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready  AXI-lite read channels  master  ADDR_WIDTH/1/1, 32/2/1/1.
REQ-015 m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI-lite write channels  master  ADDR_WIDTH/1/1, 32/4/1/1, 2/1/1.

Function
REQ-016 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR.
REQ-017 IDLE to RD_ADDR on an accepted aligned load; to WR_REQ on an accepted aligned store; to ERR on an accepted misaligned access.
REQ-018 Misaligned: size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size 3 always. ERR issues no AXI traffic, pulses resp_valid with resp_err=1 for one cycle, then returns to IDLE.
REQ-019 Request fields are registered on acceptance; AXI outputs derive only from the registered copy.
REQ-020 araddr and awaddr SHALL equal the registered addr with bits [1:0] forced to 0.
REQ-021 RD_ADDR: arvalid=1 until arready, then RD_DATA; arvalid first rises the cycle after acceptance.
REQ-022 RD_DATA: rready=1; on rvalid, register the data and pulse resp_valid the next cycle, then return to IDLE. rready is 0 in every other state.
REQ-023 Load extraction: shift rdata right by 8*addr[1:0], take the low 8/16/32 bits, then sign- or zero-extend per req_signed.
REQ-024 WR_REQ: awvalid and wvalid both rise together; each drops independently after its own handshake (per-channel done flags). Enter WR_RESP once both are done, including the case where both handshakes occur in the same cycle.
REQ-025 Store lane: wstrb = 4'b0001, 4'b0011 or 4'b1111 for byte/half/word, shifted left by addr[1:0].
REQ-026 Store data: wdata = req_wdata[7:0] replicated x4 for byte, req_wdata[15:0] replicated x2 for half, unchanged for word.
REQ-027 WR_RESP: bready=1; on bvalid, pulse resp_valid the next cycle with resp_err=(bresp!=0), then return to IDLE.
REQ-028 A read error is rresp!=0; it gives resp_err=1 and resp_rdata=0.
REQ-029 One outstanding request maximum; back-to-back requests are separated by at least one IDLE cycle.
REQ-030 AXI valid signals SHALL never drop before their handshake; addr/data/strb are held stable while valid is high.

Reset
REQ-031 When rst is asserted (asynchronously): state=IDLE, all valid/ready outputs 0 except req_ready (becomes 1 after release), resp_rdata=0, resp_err=0, done flags cleared.
REQ-032 Reset mid-transaction abandons the transaction with no response; the interconnect is reset by the same rst.

Structure
REQ-033 A shared package lsu_pkg holds the state enum, the size codes (SZ_B/SZ_H/SZ_W) and the OKAY response constant.
REQ-034 The combinational lane logic (wstrb/wdata generation, load extract/extend, misalign check) lives in one sub-module, lsu_align. The FSM stays in lsu_axi.

Verification
REQ-035 Load byte signed, addr 0x1003, rdata 0x80xxxxxx -> araddr 0x1000, resp_rdata 0xFFFFFF80, resp_err 0.
REQ-036 Store half, addr 0x2002, wdata 0x1234ABCD -> awaddr 0x2000, wstrb 4'b1100, wdata 0xABCDABCD; awready delayed 3 cycles after wready -> exactly one resp_valid, resp_err 0.
REQ-037 Load word, addr 0x3001 -> no arvalid ever; resp_valid pulses 2 cycles after acceptance with resp_err 1.
REQ-038 Load half unsigned, addr 0x4002, rdata 0xBEEF0000, rresp 2'b10 -> resp_err 1, resp_rdata 0; then 0x4002 with rresp OKAY -> resp_rdata 0x0000BEEF.
REQ-039 rst asserted while in RD_DATA -> arvalid/rready/resp_valid are 0 immediately; a new load after release completes normally.
REQ-040 Store with awready and wready high in the same cycle -> WR_RESP the next cycle; bvalid followed by resp_valid one cycle later.
